// File: rtl/fifo_arb_pkg.sv
// Shared constants for the two-producer FIFO front end.
package fifo_arb_pkg;

  localparam int unsigned DEPTH_DEF      = 8;
  localparam int unsigned DATA_WIDTH_DEF = 4;
  localparam int unsigned CAP_DEF        = DEPTH_DEF - 1;
  localparam int unsigned COUNT_W_DEF    = $clog2(DEPTH_DEF) + 1;

  // One entry is always kept free, so the usable capacity is DEPTH-1.
  function automatic int unsigned cap_of(input int unsigned depth);
    return depth - 1;
  endfunction

  function automatic int unsigned count_w_of(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_arb_rr_arb2.sv
// Two-way round-robin arbiter; prio names the winner when both request.
module rr_arb2 (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  logic prio_q;

  always_comb begin
    gnt0 = en & req0 & (~req1 | ~prio_q);
    gnt1 = en & req1 & (~req0 | prio_q);
  end

  // Winner k hands priority to the other requester; no grant holds it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q <= 1'b0;
    end else if (gnt0) begin
      prio_q <= 1'b1;
    end else if (gnt1) begin
      prio_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fifo_arb.sv
// Arbitrated write port, pop control and occupancy tracking for an external FIFO.
module fifo_arb
  import fifo_arb_pkg::*;
#(
  parameter  int unsigned DEPTH      = DEPTH_DEF,
  parameter  int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int unsigned CAP        = cap_of(DEPTH),
  localparam int unsigned CW         = count_w_of(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic [DATA_WIDTH-1:0] data0_i,
  input  logic [DATA_WIDTH-1:0] data1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  input  logic                  pop_i,
  output logic                  rvalid_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0] fifo_wdata_o,
  output logic                  fifo_rd_en_o,
  input  logic [DATA_WIDTH-1:0] fifo_data_i,
  output logic                  fifo_rst_no,
  output logic [CW-1:0]         count_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          rvalid_q;
  logic          wr_ok;
  logic          wr_acc;
  logic          pop_ok;

  // Reset is folded into the enables so nothing fires while rst_ni is low.
  assign wr_ok  = rst_ni & ~flush_i & (count_q < CW'(CAP));
  assign pop_ok = rst_ni & ~flush_i & pop_i & (count_q != '0);
  assign wr_acc = gnt0_o | gnt1_o;

  rr_arb2 u_arb (
    .clk  (clk_i),
    .rst_n(rst_ni),
    .en   (wr_ok),
    .req0 (req0_i),
    .req1 (req1_i),
    .gnt0 (gnt0_o),
    .gnt1 (gnt1_o)
  );

  always_comb begin
    count_d = count_q;
    case ({wr_acc, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q  <= '0;
      rvalid_q <= 1'b0;
    end else if (flush_i) begin
      count_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rvalid_q <= pop_ok;
    end
  end

  assign fifo_wr_en_o = wr_acc;
  assign fifo_wdata_o = gnt1_o ? data1_i : data0_i;
  assign fifo_rd_en_o = pop_ok;
  assign fifo_rst_no  = rst_ni & ~flush_i;
  assign rvalid_o     = rvalid_q;
  assign rdata_o      = fifo_data_i;
  assign count_o      = count_q;
  assign full_o       = rst_ni & (count_q == CW'(CAP));
  assign empty_o      = ~rst_ni | (count_q == '0);

endmodule
